// File: rtl/div_pkg.sv
// Shared types and sizes for the div_ctrl signed divide sequencer.
// FIX_R exists only when DIV_REMAINDER_EN is defined.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    IDLE,
    ABS_A,
    ABS_B,
    ITER,
    FIXUP,
`ifdef DIV_REMAINDER_EN
    FIX_R,
`endif
    DONE
  } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration down-counter for div_ctrl: parallel load, count enable and
// a terminal-count flag that is high while the count is zero.
module div_iter_counter
  import div_pkg::*;
#(
  parameter int W = DIV_CNT_W
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed restoring divider sequencer driving a shared add/sub ALU.
// Define DIV_REMAINDER_EN to add the data_remainder port and the FIX_R state.
//
// state | meaning
// IDLE  | waiting for ctrl_DIV
// ABS_A | ALU forms 0 - A, latch |A| as the initial quotient shift register
// ABS_B | ALU forms 0 - B, latch |B| as divisor; divide-by-zero exits to DONE
// ITER  | one restoring step per cycle, 32 cycles
// FIXUP | apply quotient sign via ALU negate
// FIX_R | apply remainder sign (dividend sign) via ALU negate
// DONE  | one-cycle data_resultRDY pulse
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] alu_opA,
  output logic [WIDTH-1:0] alu_opB,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             sign_quo_q, sign_quo_d;
`ifdef DIV_REMAINDER_EN
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] rem_q, rem_d;
`endif

  logic             cnt_load, cnt_en, cnt_tc;
  logic [WIDTH-1:0] r_shift;

  div_iter_counter #(.W(DIV_CNT_W)) u_iter_cnt (
    .clock_i    (clock),
    .reset_i    (reset),
    .load_i     (cnt_load),
    .load_val_i (DIV_CNT_W'(DIV_ITERS - 1)),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    result_d   = result_q;
    exc_d      = exc_q;
    sign_quo_d = sign_quo_q;
`ifdef DIV_REMAINDER_EN
    sign_rem_d = sign_rem_q;
    rem_d      = rem_q;
`endif
    alu_opA    = '0;
    alu_opB    = '0;
    alu_sub    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    // R stays below D <= 2^31, so its top bit is always zero and can be shifted out.
    r_shift    = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    unique case (state_q)
      IDLE: ;
      ABS_A: begin
        alu_opB = a_q;
        alu_sub = 1'b1;
        q_d     = a_q[WIDTH-1] ? alu_result : a_q;
        r_d     = '0;
        state_d = ABS_B;
      end
      ABS_B: begin
        alu_opB = b_q;
        alu_sub = 1'b1;
        d_d     = b_q[WIDTH-1] ? alu_result : b_q;
        if (b_q == '0) begin
          exc_d    = 1'b1;
          result_d = '0;
`ifdef DIV_REMAINDER_EN
          rem_d    = '0;
`endif
          state_d  = DONE;
        end else begin
          cnt_load = 1'b1;
          state_d  = ITER;
        end
      end
      ITER: begin
        alu_opA = r_shift;
        alu_opB = d_q;
        alu_sub = 1'b1;
        cnt_en  = 1'b1;
        if (alu_cout) begin
          r_d = alu_result;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_tc) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        alu_opB  = q_q;
        alu_sub  = 1'b1;
        result_d = sign_quo_q ? alu_result : q_q;
`ifdef DIV_REMAINDER_EN
        state_d  = FIX_R;
`else
        state_d  = DONE;
`endif
      end
`ifdef DIV_REMAINDER_EN
      FIX_R: begin
        alu_opB = r_q;
        alu_sub = 1'b1;
        rem_d   = sign_rem_q ? alu_result : r_q;
        state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start pulse wins in every state; an operation in flight is dropped without RDY.
    if (ctrl_DIV) begin
      a_d        = data_operandA;
      b_d        = data_operandB;
      sign_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      result_d   = '0;
      exc_d      = 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_rem_d = data_operandA[WIDTH-1];
      rem_d      = '0;
`endif
      state_d    = ABS_A;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      sign_quo_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_rem_q <= 1'b0;
      rem_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      sign_quo_q <= sign_quo_d;
`ifdef DIV_REMAINDER_EN
      sign_rem_q <= sign_rem_d;
      rem_q      <= rem_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
`ifdef DIV_REMAINDER_EN
  assign data_remainder = rem_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: a behavioural ALU, an arithmetic reference
// model, directed cases plus randomized operands; honours DIV_REMAINDER_EN.
module tb_div_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic        alu_sub, alu_cout;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
  localparam int LAT_NORM = 36;
`else
  localparam int LAT_NORM = 35;
`endif
  localparam int LAT_DIV0 = 2;

  logic [32:0] alu_sum;
  assign alu_sum    = {1'b0, alu_opA} + {1'b0, (alu_sub ? ~alu_opB : alu_opB)} + {32'b0, alu_sub};
  assign alu_result = alu_sum[31:0];
  assign alu_cout   = alu_sum[32];

  div_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_opA        (alu_opA),
    .alu_opB        (alu_opB),
    .alu_sub        (alu_sub),
    .alu_result     (alu_result),
    .alu_cout       (alu_cout),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] rem;
    int          rdy_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [31:0] last_res;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: truncating signed division on 64-bit integers, keeping the low 32 bits.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint la, lb, q, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      e.res = 32'h0; e.exc = 1'b1; e.rem = 32'h0; e.rdy_cyc = LAT_DIV0;
    end else begin
      q = la / lb;
      r = la % lb;
      e.res = q[31:0]; e.exc = 1'b0; e.rem = r[31:0]; e.rdy_cyc = LAT_NORM;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (data_resultRDY) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdy: RDY high with no operation pending (cyc=%0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdy_latency", cyc, e.rdy_cyc);
        check("result", data_result, e.res);
        check("exception", {31'b0, data_exception}, {31'b0, e.exc});
`ifdef DIV_REMAINDER_EN
        check("remainder", data_remainder, e.rem);
`endif
        check("alu_idle_in_done", {alu_opA ^ alu_opB, 31'b0, alu_sub} == 64'b0 ? 32'h0 : 32'h1, 32'h0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    e = model(a, b);
    e.rdy_cyc = e.rdy_cyc + cyc;
    last_res = e.res;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clock);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: RDY not seen within 60 cycles, %0d pending", sb.size());
      sb.delete();
    end
    @(negedge clock);
    check("result_held", data_result, last_res);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_done();
  endtask

  initial begin
    logic [31:0] ra, rb;
    int mode;
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    last_res = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'h0);
    check("reset_exception", {31'b0, data_exception}, 32'h0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    check("reset_alu_opA", alu_opA, 32'h0);
    check("reset_alu_opB", alu_opB, 32'h0);
    check("reset_alu_sub", {31'b0, alu_sub}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    run(32'd100, 32'd7);
    run(32'hFFFFFF9C, 32'd7);
    run(32'd55, 32'd0);
    run(32'h80000000, 32'hFFFFFFFF);
    run(32'h80000000, 32'd1);
    run(32'h80000000, 32'h80000000);
    run(32'd7, 32'h80000000);
    run(32'd100, 32'hFFFFFFF9);

    // Restart at edge 10: the 100/7 entry is dropped, only 20/3 may complete.
    issue(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    sb.delete();
    issue(32'd20, 32'd3);
    wait_done();

    // Asynchronous reset in the middle of ITER.
    issue(32'd100, 32'd7);
    repeat (12) @(posedge clock);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("midreset_alu_sub", {31'b0, alu_sub}, 32'h0);
    check("midreset_alu_opB", alu_opB, 32'h0);
    check("midreset_result", data_result, 32'h0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (45) @(posedge clock);
    run(32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      ra = $urandom();
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      case (mode)
        0: rb = 32'h0;
        1: rb = 32'($signed($urandom_range(0, 20)) - 10);
        2: rb = $urandom();
        3: rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
        default: rb = {16'h0, 16'($urandom())};
      endcase
      run(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle signed 32-bit integer divide sequencer.
- Does not own an adder: each cycle it drives the processor's shared 32-bit add/sub ALU, whose subtract path inverts operand B and adds 1.
- Runs restoring division in 32 iterations, plus setup (absolute values) and sign fix-up; pulses a ready flag when done.
- Sits beside the multiplier in the multdiv unit; the execute stage stalls on it.

Parameters:
- WIDTH, 32, operand, result and ALU width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- ctrl_DIV  in  1  start pulse; operands sampled on the same edge.
- data_operandA  in  WIDTH  dividend, two's complement.
- data_operandB  in  WIDTH  divisor, two's complement.
- alu_opA  out  WIDTH  shared ALU operand A.
- alu_opB  out  WIDTH  shared ALU operand B.
- alu_sub  out  1  1 = ALU computes opA + ~opB + 1.
- alu_result  in  WIDTH  shared ALU sum, combinational from alu_opA, alu_opB and alu_sub.
- alu_cout  in  1  ALU carry-out; on subtract, 1 = no borrow (opA >= opB unsigned).
- data_result  out  WIDTH  quotient; held until the next ctrl_DIV.
- data_exception  out  1  divide-by-zero flag; held like data_result.
- data_resultRDY  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async): state IDLE; all registers and outputs 0, including alu_opA, alu_opB and alu_sub.
- States: IDLE, ABS_A, ABS_B, ITER, FIXUP, DONE.
- ctrl_DIV is sampled at any edge, any state.
  - Latches A and B, sign_q = A[31] ^ B[31], sign_r = A[31].
  - Clears data_result and data_exception; next state ABS_A.
  - A start while busy aborts the current operation silently; no RDY is issued for it.
- ABS_A: ALU computes 0 - A (opA 0, opB A, sub 1). Register |A| = A[31] ? alu_result : A. R = 0, Q = |A|.
- ABS_B: same for B, giving D = |B|.
  - If B == 0: data_exception = 1, data_result = 0, go to DONE.
  - Otherwise load the 5-bit counter with 31 and go to ITER.
- ITER, each cycle:
  - Rs = {R[30:0], Q[31]}; ALU computes Rs - D.
  - If alu_cout: R = alu_result, Q = {Q[30:0], 1}.
  - Else: R = Rs, Q = {Q[30:0], 0}.
  - Counter decrements; after the count-0 cycle, go to FIXUP. Exactly 32 ITER cycles.
  - R never exceeds 32 bits unsigned, because D <= 2^31.
- FIXUP: ALU computes 0 - Q; data_result = sign_q ? alu_result : Q. Next state DONE.
- DONE: data_resultRDY = 1 for this one cycle; next state IDLE.
- Outside ABS_A, ABS_B, ITER and FIXUP: alu_opA = 0, alu_opB = 0, alu_sub = 0.
- Latency, with ctrl_DIV sampled at edge 0:
  - Normal: RDY high in the cycle after edge 35.
  - Divide by zero: RDY high in the cycle after edge 2.
- Overflow: 0x80000000 / 0xFFFFFFFF = 0x80000000, data_exception = 0 (natural wrap).
- Reset mid-operation: immediate IDLE, no RDY, outputs 0.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined:
  - Adds output port data_remainder, WIDTH bits.
  - Adds state FIX_R after FIXUP: ALU computes 0 - R; data_remainder = sign_r ? alu_result : R.
  - Normal latency grows by one (RDY after edge 36).
  - Divide by zero gives data_remainder = 0.
  - Reset value 0; held like data_result.
- Undefined: no port and no FIX_R; latency as above.

Decomposition:
- Package div_pkg holds:
  - state enum div_state_t.
  - DIV_W = 32.
  - DIV_CNT_W = 5.
  - DIV_ITERS = 32.
- One sub-module, div_iter_counter: 5-bit down-counter with load, enable and a terminal-count flag. Its async active-high reset uses the same clock and reset as div_ctrl.

Test Plan:
- A = 100, B = 7, ctrl_DIV at edge 0 -> RDY pulse after edge 35 only; result 14; exception 0.
- A = -100 (0xFFFFFF9C), B = 7 -> result 0xFFFFFFF2 (-14). With DIV_REMAINDER_EN: data_remainder 0xFFFFFFFE (-2), RDY after edge 36.
- A = 55, B = 0 -> RDY after edge 2; exception 1; result 0; alu_sub back to 0 in DONE.
- A = 0x80000000, B = 0xFFFFFFFF -> result 0x80000000; exception 0. Also A = 0x80000000, B = 1 -> 0x80000000.
- Start 100/7 at edge 0, restart with 20/3 at edge 10 -> no RDY near edge 35; single RDY after edge 45; result 6.
- Assert reset asynchronously mid-ITER (edge 12) -> outputs 0 immediately, no RDY afterwards; new ctrl_DIV 9/3 after release -> result 3 at the normal latency.
